// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution unit: ARM condition codes,
// NZCV bit positions and the exception-banking FSM states.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        NORM = 1'b0,
        EXC  = 1'b1
    } state_e;

endpackage

// File: rtl/cond_eval.sv
// Purely combinational ARM condition evaluator: maps the 4-bit condition
// field and the current NZCV flags to a pass/fail bit.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    // NOTE: give every always_comb output a value before the case so no path leaves it unassigned (no latch).
    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            COND_AL: CondEx = 1'b1;
            COND_NV: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit: NZCV flag register, condition gating of decoder
// strobes and a saturating squash counter. COND_UNIT_SAVED_FLAGS_EN adds flag banking across exceptions.
module cond_unit
    import cond_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             instr_valid,
    input  logic             cnt_clr,
`ifdef COND_UNIT_SAVED_FLAGS_EN
    input  logic             ExcEntry,
    input  logic             ExcReturn,
    output logic [3:0]       SavedFlags,
    output logic             in_exc,
`endif
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] squash_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic       exec;
    logic [3:0] flags_wr;

    cond_eval u_eval (
        .Cond   (Cond),
        .Flags  (Flags),
        .CondEx (CondEx)
    );

    assign exec     = instr_valid & CondEx;
    assign PCSrc    = PCS & exec;
    assign RegWrite = RegW & exec & ~NoWrite;
    assign MemWrite = MemW & exec;

    // Flag value an executing instruction would leave; N/Z and C/V load independently.
    always_comb begin
        flags_wr = Flags;
        if (exec) begin
            if (FlagW[1]) begin
                flags_wr[FLAG_N] = ALUFlags[FLAG_N];
                flags_wr[FLAG_Z] = ALUFlags[FLAG_Z];
            end
            if (FlagW[0]) begin
                flags_wr[FLAG_C] = ALUFlags[FLAG_C];
                flags_wr[FLAG_V] = ALUFlags[FLAG_V];
            end
        end
    end

`ifdef COND_UNIT_SAVED_FLAGS_EN
    state_e state;

    assign in_exc = (state == EXC);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= NORM;
            Flags      <= 4'b0000;
            SavedFlags <= 4'b0000;
        end else begin
            case (state)
                NORM: begin
                    if (ExcEntry) begin
                        SavedFlags <= Flags;
                        state      <= EXC;
                    end else begin
                        Flags <= flags_wr;
                    end
                end
                EXC: begin
                    // Restoring the banked flags takes priority over this cycle's ALU write.
                    if (ExcReturn) begin
                        Flags <= SavedFlags;
                        state <= NORM;
                    end else begin
                        Flags <= flags_wr;
                    end
                end
                default: state <= NORM;
            endcase
        end
    end
`else
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Flags <= 4'b0000;
        end else begin
            Flags <= flags_wr;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            squash_count <= '0;
        end else if (cnt_clr) begin
            squash_count <= '0;
        end else if (instr_valid && !CondEx && squash_count != CNT_MAX) begin
            squash_count <= squash_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: a flag/counter model checked every cycle,
// plus hand-computed directed expectations. Build with COND_UNIT_SAVED_FLAGS_EN to cover banking.
module tb_cond_unit;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] SAT = '1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       Cond = 4'd14;
    logic [3:0]       ALUFlags = 4'b0000;
    logic [1:0]       FlagW = 2'b00;
    logic             PCS = 1'b0, RegW = 1'b0, MemW = 1'b0, NoWrite = 1'b0;
    logic             instr_valid = 1'b0, cnt_clr = 1'b0;
    logic             PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0]       Flags;
    logic [CNT_W-1:0] squash_count;
`ifdef COND_UNIT_SAVED_FLAGS_EN
    logic             ExcEntry = 1'b0, ExcReturn = 1'b0;
    logic [3:0]       SavedFlags;
    logic             in_exc;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cond_unit #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .Cond         (Cond),
        .ALUFlags     (ALUFlags),
        .FlagW        (FlagW),
        .PCS          (PCS),
        .RegW         (RegW),
        .MemW         (MemW),
        .NoWrite      (NoWrite),
        .instr_valid  (instr_valid),
        .cnt_clr      (cnt_clr),
`ifdef COND_UNIT_SAVED_FLAGS_EN
        .ExcEntry     (ExcEntry),
        .ExcReturn    (ExcReturn),
        .SavedFlags   (SavedFlags),
        .in_exc       (in_exc),
`endif
        .PCSrc        (PCSrc),
        .RegWrite     (RegWrite),
        .MemWrite     (MemWrite),
        .CondEx       (CondEx),
        .Flags        (Flags),
        .squash_count (squash_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ARM evaluates condition pairs: odd codes are the inverse of the even code below them.
    function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf && !z;
            3'd5:    base = (n == v);
            3'd6:    base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    logic [3:0]       m_flags, m_saved, m_next;
    logic [CNT_W-1:0] m_cnt;
    logic             m_exc, m_pass;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_flags = 4'b0000;
            m_saved = 4'b0000;
            m_cnt   = '0;
            m_exc   = 1'b0;
        end else begin
            m_pass = model_cond(Cond, m_flags);
            m_next = m_flags;
            if (instr_valid && m_pass) begin
                if (FlagW[1]) m_next[3:2] = ALUFlags[3:2];
                if (FlagW[0]) m_next[1:0] = ALUFlags[1:0];
            end
`ifdef COND_UNIT_SAVED_FLAGS_EN
            if (!m_exc && ExcEntry) begin
                m_saved = m_flags;
                m_next  = m_flags;
                m_exc   = 1'b1;
            end else if (m_exc && ExcReturn) begin
                m_next = m_saved;
                m_exc  = 1'b0;
            end
`endif
            m_flags = m_next;
            if (cnt_clr) m_cnt = '0;
            else if (instr_valid && !m_pass && m_cnt != SAT) m_cnt = m_cnt + 1'b1;
        end
    end

    always @(negedge clk) begin
        logic p;
        if (rst_n) begin
            p = model_cond(Cond, m_flags);
            check("cmp_CondEx",   32'(CondEx),       32'(p));
            check("cmp_PCSrc",    32'(PCSrc),        32'(PCS && p && instr_valid));
            check("cmp_RegWrite", 32'(RegWrite),     32'(RegW && p && !NoWrite && instr_valid));
            check("cmp_MemWrite", 32'(MemWrite),     32'(MemW && p && instr_valid));
            check("cmp_Flags",    32'(Flags),        32'(m_flags));
            check("cmp_count",    32'(squash_count), 32'(m_cnt));
`ifdef COND_UNIT_SAVED_FLAGS_EN
            check("cmp_SavedFlags", 32'(SavedFlags), 32'(m_saved));
            check("cmp_in_exc",     32'(in_exc),     32'(m_exc));
`endif
        end
    end

    task automatic apply(input logic [3:0] c, input logic [3:0] alu, input logic [1:0] fw,
                         input logic pcs_i, input logic regw_i, input logic memw_i,
                         input logic nw, input logic valid, input logic clr);
        Cond = c; ALUFlags = alu; FlagW = fw;
        PCS = pcs_i; RegW = regw_i; MemW = memw_i; NoWrite = nw;
        instr_valid = valid; cnt_clr = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_flags(input logic [3:0] f);
        apply(4'd14, f, 2'b11, 0, 0, 0, 0, 1, 0);
        tick();
    endtask

    initial begin
        logic [3:0] sweep [6];
        sweep = '{4'b0000, 4'b0100, 4'b0010, 4'b1001, 4'b1000, 4'b0110};

        #12 rst_n = 1'b1;
        tick();
        check("reset_Flags", 32'(Flags), 32'h0);
        check("reset_count", 32'(squash_count), 32'h0);

        // EQ with Z=0 fails and is squashed
        apply(4'd0, 4'h0, 2'b00, 0, 1, 0, 0, 1, 0);
        #1;
        check("eq_reset_CondEx", 32'(CondEx), 32'h0);
        check("eq_reset_RegWrite", 32'(RegWrite), 32'h0);
        tick();
        check("first_squash_count", 32'(squash_count), 32'h1);

        load_flags(4'b0100);
        check("flags_0100", 32'(Flags), 32'h4);
        apply(4'd0, 4'h0, 2'b00, 0, 0, 0, 0, 1, 0);
        #1;
        check("eq_z1_CondEx", 32'(CondEx), 32'h1);
        apply(4'd1, 4'h0, 2'b00, 1, 0, 0, 0, 1, 0);
        #1;
        check("ne_z1_PCSrc", 32'(PCSrc), 32'h0);
        tick();

        // C/V half loads independently of N/Z
        load_flags(4'b1000);
        apply(4'd14, 4'b0011, 2'b01, 0, 0, 0, 0, 1, 0);
        tick();
        check("flags_1011", 32'(Flags), 32'hb);
        apply(4'd10, 4'h0, 2'b00, 0, 0, 0, 0, 1, 0);
        #1;
        check("ge_CondEx", 32'(CondEx), 32'h1);
        apply(4'd11, 4'h0, 2'b00, 0, 0, 0, 0, 1, 0);
        #1;
        check("lt_CondEx", 32'(CondEx), 32'h0);
        tick();

        // failing condition must not write flags
        apply(4'd15, 4'b0000, 2'b11, 0, 0, 0, 0, 1, 0);
        tick();
        check("nv_no_flag_write", 32'(Flags), 32'hb);

        foreach (sweep[i]) begin
            load_flags(sweep[i]);
            for (int c = 0; c < 16; c++) begin
                apply(4'(c), 4'h0, 2'b00, 1, 1, 1, c[0], 1, 0);
                tick();
            end
        end

        apply(4'd14, 4'h0, 2'b00, 0, 0, 0, 0, 0, 1);
        tick();
        check("clr_count", 32'(squash_count), 32'h0);
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            apply(4'd15, 4'h0, 2'b00, 0, 0, 1, 0, 1, 0);
            #1;
            check("nv_MemWrite", 32'(MemWrite), 32'h0);
            tick();
        end
        check("count_saturated", 32'(squash_count), 32'hf);
        apply(4'd15, 4'h0, 2'b00, 0, 0, 1, 0, 1, 1);
        tick();
        check("clr_beats_inc", 32'(squash_count), 32'h0);

`ifdef COND_UNIT_SAVED_FLAGS_EN
        load_flags(4'b0110);
        ExcEntry = 1'b1;
        apply(4'd14, 4'b1111, 2'b11, 0, 0, 0, 0, 1, 0);
        tick();
        ExcEntry = 1'b0;
        check("entry_SavedFlags", 32'(SavedFlags), 32'h6);
        check("entry_Flags_kept", 32'(Flags), 32'h6);
        check("entry_in_exc", 32'(in_exc), 32'h1);
        load_flags(4'b1001);
        check("exc_write", 32'(Flags), 32'h9);
        ExcEntry = 1'b1;
        apply(4'd14, 4'h0, 2'b00, 0, 0, 0, 0, 1, 0);
        tick();
        check("entry_in_exc_ignored", 32'(SavedFlags), 32'h6);
        ExcReturn = 1'b1;
        apply(4'd14, 4'b0000, 2'b11, 0, 0, 0, 0, 1, 0);
        tick();
        ExcEntry = 1'b0;
        check("return_Flags", 32'(Flags), 32'h6);
        check("return_in_exc", 32'(in_exc), 32'h0);
        apply(4'd14, 4'b0011, 2'b11, 0, 0, 0, 0, 1, 0);
        tick();
        ExcReturn = 1'b0;
        check("return_in_norm_ignored", 32'(Flags), 32'h3);
        check("return_in_norm_state", 32'(in_exc), 32'h0);
`endif

        load_flags(4'b0101);
        apply(4'd14, 4'h0, 2'b00, 0, 0, 0, 0, 0, 1);
        tick();
        apply(4'd14, 4'b1111, 2'b11, 1, 1, 1, 0, 0, 0);
        #1;
        check("invalid_PCSrc", 32'(PCSrc), 32'h0);
        check("invalid_RegWrite", 32'(RegWrite), 32'h0);
        check("invalid_MemWrite", 32'(MemWrite), 32'h0);
        tick();
        check("invalid_Flags", 32'(Flags), 32'h5);
        check("invalid_count", 32'(squash_count), 32'h0);

        // asynchronous reset in the middle of a pending flag write
        apply(4'd14, 4'b1010, 2'b11, 0, 0, 0, 0, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_Flags", 32'(Flags), 32'h0);
        check("midreset_count", 32'(squash_count), 32'h0);
        tick();
        check("midreset_held", 32'(Flags), 32'h0);
        apply(4'd14, 4'h0, 2'b00, 0, 0, 0, 0, 0, 0);
        #3 rst_n = 1'b1;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
# cond_unit

Conditional-execution unit for the single-cycle ARM datapath: the consumer of the ALU's `{N,Z,C,V}` flag vector. It holds the architectural NZCV flag register and evaluates the 4-bit condition field against it. It gates the decoder's write and branch strobes, counts squashed instructions, and optionally banks flags across exception entry and return. It sits between the main decoder/ALU and the register file, data memory and PC mux.

## Interface
- `CNT_W`, default 16: width of the squash counter.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `Cond` in 4: instruction condition field, instr[31:28].
- `ALUFlags` in 4: `{N,Z,C,V}` from the ALU for the current instruction.
- `FlagW` in 2: flag write enables. Bit [1] writes N,Z; bit [0] writes C,V.
- `PCS`, `RegW`, `MemW` in 1 each: ungated strobes from the decoder.
- `NoWrite` in 1: suppresses the register write (CMP/CMN/TST).
- `instr_valid` in 1: an instruction occupies the datapath this cycle.
- `cnt_clr` in 1: synchronous clear of the squash counter.
- `ExcEntry`, `ExcReturn` in 1 each: exception entry and return pulses. Present only with the macro.
- `PCSrc`, `RegWrite`, `MemWrite` out 1 each: gated strobes.
- `CondEx` out 1: condition passed.
- `Flags` out 4: current flag register, `{N,Z,C,V}`.
- `SavedFlags` out 4: banked flags. Present only with the macro.
- `in_exc` out 1: FSM is in state EXC. Present only with the macro.
- `squash_count` out `CNT_W`: count of squashed instructions.

## Operation
- Condition evaluation uses the *registered* `Flags` only. `ALUFlags` never affects `CondEx` in the same cycle.
- Condition map:
  - EQ=0: Z
  - NE=1: ~Z
  - CS=2: C
  - CC=3: ~C
  - MI=4: N
  - PL=5: ~N
  - VS=6: V
  - VC=7: ~V
  - HI=8: C&~Z
  - LS=9: ~C|Z
  - GE=10: N==V
  - LT=11: N!=V
  - GT=12: ~Z&(N==V)
  - LE=13: Z|(N!=V)
  - AL=14: 1
  - NV=15: 0
- Gated strobes:
  - `PCSrc` = `PCS & CondEx & instr_valid`.
  - `RegWrite` = `RegW & CondEx & ~NoWrite & instr_valid`.
  - `MemWrite` = `MemW & CondEx & instr_valid`.
- Flag update at a clock edge, when `instr_valid & CondEx`:
  - `FlagW[1]` loads N,Z from `ALUFlags[3:2]`.
  - `FlagW[0]` loads C,V from `ALUFlags[1:0]`.
  - The two halves are independent.
- Squash counter:
  - Increments on each edge where `instr_valid & ~CondEx`.
  - Saturates at all-ones and never wraps.
  - `cnt_clr` forces 0 and wins over a simultaneous increment.
- `instr_valid`=0 means: no flag write, no count, and all gated strobes are 0.

## Timing
- `CondEx` and the gated strobes are combinational from `Cond`, `Flags` and the strobes, with zero latency.
- A flag write becomes visible on `Flags` and `CondEx` in the cycle after the writing instruction.
- `squash_count` updates one cycle after the squashed instruction.
- Reset (async assert, sync-safe deassert) values:
  - `Flags`=0000, `SavedFlags`=0000, `squash_count`=0, FSM=NORM, `in_exc`=0.
  - The combinational outputs follow from these, e.g. `Cond`=EQ gives `CondEx`=0.
- Reset mid-operation: all state clears immediately. Pending flag writes are lost.

## Configuration
- Macro: `COND_UNIT_SAVED_FLAGS_EN`.
- When defined:
  - Adds `ExcEntry`, `ExcReturn`, `SavedFlags`, `in_exc` and a 2-state FSM: NORM, EXC.
  - NORM with `ExcEntry`: `SavedFlags` <= `Flags`, the flag write that cycle is suppressed, next state is EXC.
  - EXC with `ExcReturn`: `Flags` <= `SavedFlags` (overrides any `FlagW` write that cycle), next state is NORM.
  - `ExcEntry` in EXC is ignored; `SavedFlags` is unchanged.
  - `ExcReturn` in NORM is ignored.
  - `ExcEntry` and `ExcReturn` in the same cycle: the state's legal event acts and the other is ignored.
- When undefined: those ports and the FSM are absent, and the flags behave exactly as in Operation.

## Structure
- Shared package `cond_pkg` holds:
  - the condition-code constants COND_EQ..COND_NV;
  - the flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - the FSM state encoding NORM=0, EXC=1.
- Sub-module `cond_eval`: purely combinational. Maps `Cond` and `Flags` to `CondEx`.
- `cond_unit` contains the flag registers, counter, FSM and strobe gating.

## Test plan
- Reset, `Cond`=EQ, `RegW`=1, `instr_valid`=1 -> `CondEx`=0, `RegWrite`=0. On the next edge `squash_count`=1.
- `Cond`=AL, `FlagW`=11, `ALUFlags`=0100 -> `Flags`=0100 the next cycle. `Cond`=EQ then gives `CondEx`=1. `Cond`=NE with `PCS`=1 gives `PCSrc`=0.
- `Flags`=1000, `FlagW`=01, `ALUFlags`=0011 -> `Flags`=1011. Then `Cond`=GE gives `CondEx`=1 (N=1,V=1). `Cond`=LT gives `CondEx`=0.
- `Cond`=NV, `MemW`=1, repeated 2^`CNT_W`+3 cycles -> `MemWrite` always 0. `squash_count` saturates at all-ones. Then `cnt_clr` together with a squash gives `squash_count`=0.
- Macro defined:
  - `Flags`=0110, `ExcEntry` with `FlagW`=11 -> `SavedFlags`=0110, `Flags` still 0110, `in_exc`=1.
  - A later write sets `Flags`=1001.
  - `ExcReturn` -> `Flags`=0110, `in_exc`=0.
- `instr_valid`=0 with `Cond`=AL, `RegW`=`MemW`=`PCS`=1, `FlagW`=11 -> all gated strobes 0. `Flags` and `squash_count` are unchanged.
